sccomp_dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the single-cycle SoC top.
//  - Replaces the zero-latency data RAM with a req/ready handshake, a configurable

---
 rtl/sccomp_dmem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sccomp_dmem_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccomp_dmem_ctrl.sv
// Data-memory controller: req/ready handshake with WAIT_CYCLES wait states,
// byte-lane writes and range checking. Define MISALIGN_CHECK_EN to flag unaligned addresses as errors.
module sccomp_dmem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [31:0]         addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                busy
);

  localparam int unsigned BE_W      = DATA_W / 8;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accWe;
  logic [BE_W-1:0]   accBe;
  logic [31:0]       accAddr;
  logic [DATA_W-1:0] accWdata;
  logic [31:0]       off;
  logic              inRange;
  logic              misaligned;
  logic              accErr;
  logic              enterResp;
  logic              memWrEn;
  logic [AW-1:0]     wordIdx;

  // With zero wait states the array is touched on the accept edge itself,
  // so the live inputs must be used before the latched copy exists.
  always_comb begin
    accWe    = we_q;
    accBe    = be_q;
    accAddr  = addr_q;
    accWdata = wdata_q;
    if (state_q == ST_IDLE) begin
      accWe    = we;
      accBe    = be;
      accAddr  = addr;
      accWdata = wdata;
    end
  end

  assign off     = accAddr - BASE_ADDR;
  assign inRange = ({1'b0, off} < SPAN);
  assign wordIdx = off[AW+1:2];

`ifdef MISALIGN_CHECK_EN
  assign misaligned = (accAddr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign accErr = misaligned || !inRange;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enterResp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d = WAIT_INIT;
          if (WAIT_INIT == 4'd0) begin
            state_d   = ST_RESP;
            enterResp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_RESP;
          enterResp = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_d = 1'b0;
    if (enterResp && accErr) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == ST_IDLE && req) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enterResp) begin
        if (accErr) begin
          rdata_q <= '0;
        end else if (!accWe) begin
          rdata_q <= mem[wordIdx];
        end
      end
    end
  end

  // Reset on the commit edge discards the pending write; the array itself is never cleared.
  assign memWrEn = enterResp && accWe && !accErr && !reset;

  always_ff @(posedge clock) begin
    if (memWrEn) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (accBe[i]) begin
          mem[wordIdx][8*i +: 8] <= accWdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ready = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccomp_dmem_ctrl.sv
// Self-checking bench for sccomp_dmem_ctrl: directed cases plus randomized
// accesses against a word-array model, on a 2-wait instance and a 0-wait offset-base instance.
`timescale 1ns/1ps
module tb_sccomp_dmem_ctrl;

  localparam int          WAITS  = 2;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          WAITS0 = 0;
  localparam int          DEPTH0 = 64;
  localparam logic [31:0] BASE0  = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic        req0, we0;
  logic [3:0]  be0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, err0, busy0;

  int checks = 0;
  int passes = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] lastRd;

  sccomp_dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITS)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  sccomp_dmem_ctrl #(.DATA_W(32), .DEPTH(DEPTH0), .BASE_ADDR(BASE0), .WAIT_CYCLES(WAITS0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .we(we0), .be(be0), .addr(addr0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Transaction-level model: returns the expected err flag and updates the expected rdata.
  function automatic bit modelAccess(input bit w, input logic [3:0] b, input logic [31:0] a,
                                     input logic [31:0] d);
    logic [31:0] off;
    int          idx;
    bit          bad;
    off = a - BASE;
    bad = (off >= 32'(DEPTH * 4));
`ifdef MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) bad = 1'b1;
`endif
    if (bad) begin
      lastRd = 32'd0;
      return 1'b1;
    end
    idx = int'(off / 4);
    if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end else begin
      lastRd = model[idx];
    end
    return 1'b0;
  endfunction

  task automatic applyStimulus(input bit w, input logic [3:0] b, input logic [31:0] a,
                               input logic [31:0] d);
    bit expErr;
    int cycles;
    expErr = modelAccess(w, b, a, d);
    @(negedge clock);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clock);
    req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
    checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    cycles = 1;
    while (!ready && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'(WAITS + 1));
    checkOutput("err", 32'(err), 32'(expErr));
    checkOutput("rdata", rdata, lastRd);
    @(negedge clock);
    checkOutput("readyPulse", 32'(ready), 32'd0);
    checkOutput("busyIdle", 32'(busy), 32'd0);
    checkOutput("errClear", 32'(err), 32'd0);
  endtask

  task automatic applyStimulus0(input bit w, input logic [3:0] b, input logic [31:0] a,
                                input logic [31:0] d, input bit expErr, input logic [31:0] expRd);
    int cycles;
    @(negedge clock);
    req0 = 1'b1; we0 = w; be0 = b; addr0 = a; wdata0 = d;
    @(negedge clock);
    req0 = 1'b0; addr0 = $urandom; wdata0 = $urandom;
    cycles = 1;
    while (!ready0 && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    checkOutput("latency0", 32'(cycles), 32'(WAITS0 + 1));
    checkOutput("err0", 32'(err0), 32'(expErr));
    checkOutput("rdata0", rdata0, expRd);
    @(negedge clock);
    checkOutput("readyPulse0", 32'(ready0), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int          pulses;
    int          pool [16];
    int          idx;
    bit          w;
    logic [31:0] a;

    reset = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 32'd0; wdata0 = 32'd0;
    lastRd = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstReady", 32'(ready), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstErr", 32'(err), 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    checkOutput("rstRdata0", rdata0, 32'd0);

    // Pool of words touched by the randomized phase; fully written first so every read is defined.
    for (int i = 0; i < 12; i++) pool[i] = 4 + i;
    for (int i = 0; i < 4; i++) pool[12 + i] = DEPTH - 4 + i;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'hF, BASE + 32'(pool[i] * 4), $urandom);

    // Reset during WAIT discards the write.
    applyStimulus(1'b1, 4'hF, 32'h10, 32'h0102_0304);
    @(negedge clock);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    lastRd = 32'd0;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstRdata", rdata, 32'd0);
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    checkOutput("midRstNoReady", 32'(pulses), 32'd0);
    applyStimulus(1'b0, 4'hF, 32'h10, 32'd0);
    checkOutput("midRstPrior", rdata, 32'h0102_0304);

    // Full write then lane-merged write.
    applyStimulus(1'b1, 4'hF, 32'h20, 32'h1234_5678);
    applyStimulus(1'b0, 4'h0, 32'h20, 32'd0);
    checkOutput("readBack", rdata, 32'h1234_5678);
    applyStimulus(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    applyStimulus(1'b0, 4'h0, 32'h20, 32'd0);
    checkOutput("laneMerge", rdata, 32'h12BB_56DD);

    // be=0 write: no change.
    applyStimulus(1'b1, 4'h0, 32'h20, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 4'hF, 32'h20, 32'd0);
    checkOutput("beZero", rdata, 32'h12BB_56DD);

    // Range boundary.
    applyStimulus(1'b1, 4'hF, BASE + 32'(DEPTH * 4 - 4), 32'hC0FF_EE01);
    applyStimulus(1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'd0);
    checkOutput("oobRdata", rdata, 32'd0);
    applyStimulus(1'b0, 4'hF, BASE + 32'(DEPTH * 4 - 4), 32'd0);
    checkOutput("lastWord", rdata, 32'hC0FF_EE01);

    // Unaligned write to 0x22.
    applyStimulus(1'b1, 4'hF, 32'h22, 32'h5566_7788);
    applyStimulus(1'b0, 4'hF, 32'h20, 32'd0);
`ifdef MISALIGN_CHECK_EN
    checkOutput("misalign", rdata, 32'h12BB_56DD);
`else
    checkOutput("misalign", rdata, 32'h5566_7788);
`endif

    // req held through RESP: one access per WAITS+2 cycles.
    void'(modelAccess(1'b0, 4'hF, 32'h10, 32'd0));
    @(negedge clock);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
    pulses = 0;
    repeat (4 * (WAITS + 2)) begin
      @(negedge clock);
      if (ready) pulses++;
    end
    req = 1'b0;
    checkOutput("heldPulses", 32'(pulses), 32'd4);
    checkOutput("heldIdle", 32'(busy), 32'd0);
    checkOutput("heldRdata", rdata, lastRd);

    // Randomized accesses over the pool plus out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: a = BASE + 32'(DEPTH * 4) + 4 * 32'($urandom_range(0, 255));
          1: a = BASE - 4 * 32'($urandom_range(1, 64));
          default: a = 32'hFFFF_FFFC;
        endcase
      end else begin
        idx = pool[$urandom_range(0, 15)];
        a = BASE + 32'(idx * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      end
      applyStimulus(w, 4'($urandom), a, $urandom);
    end

    // Zero-wait instance with a nonzero base.
    applyStimulus0(1'b1, 4'hF, BASE0 + 32'd20, 32'hCAFE_F00D, 1'b0, 32'd0);
    applyStimulus0(1'b0, 4'h0, BASE0 + 32'd20, 32'd0, 1'b0, 32'hCAFE_F00D);
    applyStimulus0(1'b0, 4'hF, BASE0 - 32'd4, 32'd0, 1'b1, 32'd0);
    applyStimulus0(1'b1, 4'hF, BASE0 + 32'(DEPTH0 * 4 - 4), 32'h1122_3344, 1'b0, 32'd0);
    applyStimulus0(1'b0, 4'hF, BASE0 + 32'(DEPTH0 * 4), 32'd0, 1'b1, 32'd0);
    applyStimulus0(1'b0, 4'hF, BASE0 + 32'(DEPTH0 * 4 - 4), 32'd0, 1'b0, 32'h1122_3344);
    applyStimulus0(1'b1, 4'h0, BASE0 + 32'd20, 32'hFFFF_FFFF, 1'b0, 32'h1122_3344);
    applyStimulus0(1'b0, 4'hF, BASE0 + 32'd20, 32'd0, 1'b0, 32'hCAFE_F00D);

    @(negedge clock);
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = BASE0 + 32'd20;
    pulses = 0;
    repeat (4 * (WAITS0 + 2)) begin
      @(negedge clock);
      if (ready0) pulses++;
    end
    req0 = 1'b0;
    checkOutput("heldPulses0", 32'(pulses), 32'd4);
    checkOutput("heldIdle0", 32'(busy0), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
